// File: rtl/noc_xfer_scheduler.sv
// Transfer scheduler for the 4-port NoC router: picks one deliverable input head
// flit per round (round-robin with starvation override) and strobes the FIFOs.
module noc_xfer_scheduler #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEST_LSB = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        in_empty,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic [DATA_W-1:0] in_data_2,
    input  logic [DATA_W-1:0] in_data_3,
    input  logic [3:0]        out_full,
    output logic [3:0]        in_rd_en,
    output logic [3:0]        out_wr_en,
    output logic [DATA_W-1:0] out_data,
    output logic              grant_valid,
    output logic [1:0]        grant_src,
    output logic [1:0]        grant_dst,
    output logic              busy,
    output logic [15:0]       xfer_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARB  = 2'd1;
    localparam logic [1:0] XFER = 2'd2;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        rr_ptr;
    logic [7:0]        wait_cnt [4];
    logic [DATA_W-1:0] head     [4];
    logic [1:0]        dest     [4];
    logic [3:0]        eligible;
    logic [3:0]        starved;
    logic              pick_valid;
    logic [1:0]        pick;
    logic [1:0]        idx;

    assign head[0] = in_data_0;
    assign head[1] = in_data_1;
    assign head[2] = in_data_2;
    assign head[3] = in_data_3;

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            dest[i]     = head[i][DEST_LSB +: 2];
            eligible[i] = !in_empty[i] && !out_full[dest[i]];
            starved[i]  = eligible[i] && (wait_cnt[i] == WAIT_MAX);
        end
    end

    // Starved inputs win by lowest index; otherwise scan from rr_ptr with wrap.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!pick_valid && starved[i]) begin
                pick_valid = 1'b1;
                pick       = 2'(i);
            end
        end
        for (int unsigned k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? ARB : IDLE;
            ARB:     state_nxt = pick_valid ? XFER : (en ? ARB : IDLE);
            XFER:    state_nxt = en ? ARB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            in_rd_en    <= '0;
            out_wr_en   <= '0;
            out_data    <= '0;
            grant_valid <= 1'b0;
            grant_src   <= '0;
            grant_dst   <= '0;
            busy        <= 1'b0;
            xfer_count  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            in_rd_en    <= '0;
            out_wr_en   <= '0;
            grant_valid <= 1'b0;
            case (state)
                ARB: begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if ((pick_valid && pick == 2'(i)) || in_empty[i]) begin
                            wait_cnt[i] <= '0;
                        end else if (wait_cnt[i] != WAIT_MAX) begin
                            wait_cnt[i] <= wait_cnt[i] + 8'd1;
                        end
                    end
                    // Strobes are registered here so they appear exactly in the XFER cycle.
                    if (pick_valid) begin
                        in_rd_en    <= 4'b0001 << pick;
                        out_wr_en   <= 4'b0001 << dest[pick];
                        grant_valid <= 1'b1;
                        grant_src   <= pick;
                        grant_dst   <= dest[pick];
                        out_data    <= head[pick];
                    end
                end
                XFER: begin
                    rr_ptr     <= grant_src + 2'd1;
                    xfer_count <= xfer_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_xfer_scheduler.sv
// Directed and randomized bench for noc_xfer_scheduler against a queue-based
// transaction model of the FIFOs and the arbitration rules.
module tb_noc_xfer_scheduler;

    localparam int DATA_W   = 8;
    localparam int DEST_LSB = 4;
    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  in_empty;
    logic [7:0]  in_data_0, in_data_1, in_data_2, in_data_3;
    logic [3:0]  out_full;
    logic [3:0]  in_rd_en, out_wr_en;
    logic [7:0]  out_data;
    logic        grant_valid;
    logic [1:0]  grant_src, grant_dst;
    logic        busy;
    logic [15:0] xfer_count;

    noc_xfer_scheduler #(.DATA_W(DATA_W), .DEST_LSB(DEST_LSB), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_empty(in_empty),
        .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
        .out_full(out_full), .in_rd_en(in_rd_en), .out_wr_en(out_wr_en), .out_data(out_data),
        .grant_valid(grant_valid), .grant_src(grant_src), .grant_dst(grant_dst),
        .busy(busy), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int fails  = 0;
    int cyc    = 0;

    // Bench-side FIFO contents and stimulus knobs
    logic [7:0] q [4][$];
    logic [3:0] f_full;
    logic       f_en;
    logic [3:0] cur_empty;
    logic [7:0] cur_data [4];

    typedef struct {
        int         cyc;
        logic [3:0] rd;
        logic [3:0] wr;
        logic [1:0] src;
        logic [1:0] dst;
        logic [7:0] data;
    } grant_t;
    grant_t glog[$];

    // Reference model: an enabled scheduler with an optional pending transfer
    bit         m_active, m_pend;
    int         m_src, m_dst, m_rr, m_count;
    logic [7:0] m_flit;
    int         m_wait [4];
    logic [3:0] e_rd, e_wr;
    logic       e_valid, e_busy;
    logic [1:0] e_src, e_dst;
    logic [7:0] e_data;
    logic [15:0] e_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dest_of(input logic [7:0] f);
        return int'(f[DEST_LSB +: 2]);
    endfunction

    task automatic model_reset();
        m_active = 0; m_pend = 0; m_src = 0; m_dst = 0; m_rr = 0; m_count = 0; m_flit = '0;
        for (int i = 0; i < 4; i++) m_wait[i] = 0;
        e_rd = '0; e_wr = '0; e_valid = 0; e_busy = 0; e_src = '0; e_dst = '0; e_data = '0; e_count = '0;
    endtask

    task automatic model_step();
        bit elig [4];
        int pick;
        e_rd = '0; e_wr = '0; e_valid = 0;
        if (m_pend) begin
            m_pend   = 0;
            m_count  = (m_count + 1) % 65536;
            m_rr     = (m_src + 1) % 4;
            m_active = f_en;
        end else if (m_active) begin
            pick = -1;
            for (int i = 0; i < 4; i++)
                elig[i] = !cur_empty[i] && !f_full[dest_of(cur_data[i])];
            for (int i = 0; i < 4; i++)
                if (pick < 0 && elig[i] && m_wait[i] == MAX_WAIT) pick = i;
            for (int k = 0; k < 4; k++)
                if (pick < 0 && elig[(m_rr + k) % 4]) pick = (m_rr + k) % 4;
            for (int i = 0; i < 4; i++) begin
                if (i == pick || cur_empty[i]) m_wait[i] = 0;
                else if (m_wait[i] < MAX_WAIT) m_wait[i]++;
            end
            if (pick >= 0) begin
                m_pend  = 1;
                m_src   = pick;
                m_flit  = cur_data[pick];
                m_dst   = dest_of(m_flit);
                e_rd    = 4'(1 << m_src);
                e_wr    = 4'(1 << m_dst);
                e_valid = 1;
                e_src   = 2'(m_src);
                e_dst   = 2'(m_dst);
                e_data  = m_flit;
            end else begin
                m_active = f_en;
            end
        end else begin
            m_active = f_en;
        end
        e_busy  = m_active || m_pend;
        e_count = 16'(m_count);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0) begin
                cur_empty[i] = 1'b0;
                cur_data[i]  = q[i][0];
            end else begin
                cur_empty[i] = 1'b1;
                cur_data[i]  = 8'($urandom);
            end
        end
        in_empty  = cur_empty;
        in_data_0 = cur_data[0];
        in_data_1 = cur_data[1];
        in_data_2 = cur_data[2];
        in_data_3 = cur_data[3];
        out_full  = f_full;
        en        = f_en;
    endtask

    task automatic settle();
        drive_inputs();
        model_step();
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("in_rd_en", 32'(in_rd_en), 32'(e_rd));
        chk("out_wr_en", 32'(out_wr_en), 32'(e_wr));
        chk("grant_valid", 32'(grant_valid), 32'(e_valid));
        chk("grant_src", 32'(grant_src), 32'(e_src));
        chk("grant_dst", 32'(grant_dst), 32'(e_dst));
        chk("out_data", 32'(out_data), 32'(e_data));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("xfer_count", 32'(xfer_count), 32'(e_count));
        if (grant_valid === 1'b1)
            glog.push_back('{cyc, in_rd_en, out_wr_en, grant_src, grant_dst, out_data});
    endtask

    task automatic tick_rest();
        if (e_valid) void'(q[e_src].pop_front());
        settle();
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            tick_edge();
            tick_rest();
        end
    endtask

    task automatic reset_assert_check();
        rst_n = 1'b0;
        #1;
        chk("rst_in_rd_en", 32'(in_rd_en), 0);
        chk("rst_out_wr_en", 32'(out_wr_en), 0);
        chk("rst_grant_valid", 32'(grant_valid), 0);
        chk("rst_grant_src", 32'(grant_src), 0);
        chk("rst_grant_dst", 32'(grant_dst), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_xfer_count", 32'(xfer_count), 0);
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        glog.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_assert_check();
        for (int i = 0; i < 4; i++) q[i].delete();
        f_full = '0;
        f_en   = 1'b1;
        reset_release();
    endtask

    initial begin
        int found;
        rst_n = 1'b0; en = 1'b0; in_empty = '1; out_full = '0;
        in_data_0 = '0; in_data_1 = '0; in_data_2 = '0; in_data_3 = '0;
        f_full = '0; f_en = 1'b1;
        model_reset();

        // Reset and idle: enabled with nothing queued sits in arbitration
        do_reset();
        settle();
        tick(4);
        chk("idle_busy", 32'(busy), 1);
        chk("idle_no_grant", 32'(glog.size()), 0);

        // Single flit from input 2 to output 3
        do_reset();
        q[2].push_back(8'h30);
        settle();
        tick(8);
        chk("single_grants", 32'(glog.size()), 1);
        if (glog.size() > 0) begin
            chk("single_rd", 32'(glog[0].rd), 32'h4);
            chk("single_wr", 32'(glog[0].wr), 32'h8);
            chk("single_data", 32'(glog[0].data), 32'h30);
            chk("single_src", 32'(glog[0].src), 2);
            chk("single_dst", 32'(glog[0].dst), 3);
        end
        chk("single_count", 32'(xfer_count), 1);

        // Round-robin over four busy inputs, all to output 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].push_back(8'(8'h01 + i));
            q[i].push_back(8'(8'h08 + i));
        end
        settle();
        tick(20);
        chk("rr_grants", 32'(glog.size()), 8);
        if (glog.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_src", 32'(glog[k].src), 32'(k % 4));
            for (int k = 0; k < 4; k++) chk("rr_spacing", 32'(glog[k+1].cyc - glog[k].cyc), 2);
        end

        // Blocked destination: input 0 waits on full output 1
        do_reset();
        q[0].push_back(8'h10);
        for (int k = 0; k < 10; k++) q[1].push_back(8'(8'h20 + k));
        f_full = 4'b0010;
        settle();
        tick(14);
        found = 0;
        foreach (glog[k]) if (glog[k].src == 2'd0) found++;
        chk("blocked_no_src0", 32'(found), 0);
        chk("blocked_src1_served", 32'(glog.size() >= 3), 1);
        f_full = '0;
        glog.delete();
        tick(6);
        if (glog.size() > 0) chk("unblocked_src0_first", 32'(glog[0].src), 0);
        else chk("unblocked_any_grant", 32'(glog.size()), 1);

        // Starvation override: input 3 waits while 0 and 1 alternate
        do_reset();
        for (int k = 0; k < 10; k++) begin
            q[0].push_back(8'(8'h00 + k));
            q[1].push_back(8'(8'h00 + k));
        end
        q[3].push_back(8'h13);
        f_full = 4'b0010;
        settle();
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (m_pend && m_src == 0 && m_wait[3] == MAX_WAIT) found = 1;
            else tick(1);
        end
        chk("starve_setup", 32'(found), 1);
        f_full = '0;
        tick(1);
        glog.delete();
        tick(5);
        if (glog.size() > 0) chk("starve_src3_first", 32'(glog[0].src), 3);
        else chk("starve_any_grant", 32'(glog.size()), 1);

        // Randomized traffic
        do_reset();
        settle();
        for (int k = 0; k < 1500; k++) begin
            f_en   = ($urandom_range(0, 7) != 0);
            f_full = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int qi;
                qi = int'($urandom_range(0, 3));
                if (q[qi].size() < 4) q[qi].push_back(8'($urandom));
            end
            tick(1);
        end

        // Mid-transfer reset: strobes drop at once and the flit stays queued
        f_en = 1'b1;
        f_full = '0;
        q[0].push_back(8'h05);
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_pend) found = 1;
            else tick(1);
        end
        chk("midrst_setup", 32'(found), 1);
        tick_edge();
        reset_assert_check();
        chk("midrst_flits_kept", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0), 1);
        found = q[0].size() + q[1].size() + q[2].size() + q[3].size();
        reset_release();
        f_full = '0;
        settle();
        tick(12 * found + 4);
        chk("midrst_redelivered", 32'(xfer_count), 32'(found));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
